// File: rtl/shift_reg_burst.sv
// Parametrised shift register with single-step shifting in six modes and a
// self-timed burst engine that shifts a programmed number of positions.
module shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             shout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               shout_q, shout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         burstMode_q, burstMode_d;
  logic               done_q, done_d;

  logic [2:0]         shiftMode;
  logic [WIDTH-1:0]   shiftQ;
  logic               shiftOut;

  // A burst must keep the mode latched at start, even if the live mode moves.
  always_comb begin
    shiftMode = (state_q == BURST) ? burstMode_q : mode;
    shiftQ    = q_q;
    shiftOut  = shout_q;
    case (shiftMode)
      3'b001: begin
        shiftQ   = {sin_l, q_q[WIDTH-1:1]};
        shiftOut = q_q[0];
      end
      3'b010: begin
        shiftQ   = {q_q[WIDTH-2:0], sin_r};
        shiftOut = q_q[WIDTH-1];
      end
      3'b011: begin
        shiftQ   = {q_q[0], q_q[WIDTH-1:1]};
        shiftOut = q_q[0];
      end
      3'b100: begin
        shiftQ   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shiftOut = q_q[WIDTH-1];
      end
      3'b101: begin
        shiftQ   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        shiftOut = q_q[0];
      end
      default: begin
        shiftQ   = q_q;
        shiftOut = shout_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    shout_d     = shout_q;
    cnt_d       = cnt_q;
    burstMode_d = burstMode_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          q_d = data;
        end else if (start) begin
          burstMode_d = mode;
          cnt_d       = amount;
          if (amount != '0) state_d = BURST;
          else              done_d  = 1'b1;
        end else if (ena) begin
          q_d     = shiftQ;
          shout_d = shiftOut;
        end
      end
      BURST: begin
        // A load aborts the burst silently: no done pulse.
        if (load) begin
          q_d     = data;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          q_d     = shiftQ;
          shout_d = shiftOut;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      shout_q     <= 1'b0;
      cnt_q       <= '0;
      burstMode_q <= 3'b000;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      shout_q     <= shout_d;
      cnt_q       <= cnt_d;
      burstMode_q <= burstMode_d;
      done_q      <= done_d;
    end
  end

  assign q     = q_q;
  assign shout = shout_q;
  assign busy  = (state_q == BURST);
  assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_burst.sv
// Directed bench for shift_reg_burst (WIDTH=8): single steps, bursts, abort,
// reset mid-burst, zero amount, ignored start and back-to-back bursts.
module tb_shift_reg_burst;

  logic       clk;
  logic       areset_n;
  logic       load;
  logic [7:0] data;
  logic       ena;
  logic [2:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] amount;
  logic [7:0] q;
  logic       shout;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int busyCycles;

  shift_reg_burst #(.WIDTH(8)) dut (
    .clk(clk), .areset_n(areset_n), .load(load), .data(data), .ena(ena),
    .mode(mode), .sin_l(sin_l), .sin_r(sin_r), .start(start), .amount(amount),
    .q(q), .shout(shout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge sample them, return at negedge.
  task automatic applyStimulus(input logic ld, input logic [7:0] d, input logic en,
                               input logic [2:0] md, input logic st,
                               input logic [3:0] amt);
    load = ld; data = d; ena = en; mode = md; start = st; amount = amt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 4'd0);
  endtask

  initial begin
    areset_n = 1'b0; load = 0; data = 0; ena = 0; mode = 0;
    sin_l = 0; sin_r = 0; start = 0; amount = 0;
    #2;
    checkOutput("reset q", q, 8'h00);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset shout", shout, 0);
    @(negedge clk);
    areset_n = 1'b1;

    // Reset mid-burst
    applyStimulus(1, 8'hFF, 0, 3'b000, 0, 0);
    applyStimulus(0, 8'h00, 0, 3'b011, 1, 4'd5);
    checkOutput("rst burst busy", busy, 1);
    idleCycle();
    idleCycle();
    checkOutput("rst burst q", q, 8'hFF);
    checkOutput("rst burst shout", shout, 1);
    #2 areset_n = 1'b0;
    #1;
    checkOutput("rst async q", q, 8'h00);
    checkOutput("rst async shout", shout, 0);
    checkOutput("rst async busy", busy, 0);
    checkOutput("rst async done", done, 0);
    @(negedge clk);
    areset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("post rst busy", busy, 0);
      checkOutput("post rst done", done, 0);
    end

    // Single-step logical right
    applyStimulus(1, 8'hA5, 0, 3'b000, 0, 0);
    checkOutput("load q", q, 8'hA5);
    sin_l = 0;
    applyStimulus(0, 8'h00, 1, 3'b001, 0, 0);
    checkOutput("lsr q", q, 8'h52);
    checkOutput("lsr shout", shout, 1);
    sin_r = 1;
    applyStimulus(0, 8'h00, 1, 3'b010, 0, 0);
    checkOutput("lsl q", q, 8'hA5);
    checkOutput("lsl shout", shout, 0);
    applyStimulus(0, 8'h00, 1, 3'b110, 0, 0);
    checkOutput("hold110 q", q, 8'hA5);
    sin_r = 0;

    // Rotate-left burst
    applyStimulus(1, 8'h81, 0, 3'b000, 0, 0);
    applyStimulus(0, 8'h00, 0, 3'b100, 1, 4'd3);
    checkOutput("rol start q", q, 8'h81);
    checkOutput("rol start busy", busy, 1);
    idleCycle();
    checkOutput("rol q1", q, 8'h03);
    checkOutput("rol shout1", shout, 1);
    checkOutput("rol busy1", busy, 1);
    idleCycle();
    checkOutput("rol q2", q, 8'h06);
    checkOutput("rol busy2", busy, 1);
    idleCycle();
    checkOutput("rol q3", q, 8'h0C);
    checkOutput("rol busy3", busy, 0);
    checkOutput("rol done", done, 1);
    idleCycle();
    checkOutput("rol done drop", done, 0);
    checkOutput("rol final q", q, 8'h0C);

    // Arithmetic-right burst; live mode and ena changes must not matter
    applyStimulus(1, 8'h90, 0, 3'b000, 0, 0);
    applyStimulus(0, 8'h00, 0, 3'b101, 1, 4'd2);
    applyStimulus(0, 8'h00, 1, 3'b010, 0, 0);
    checkOutput("asr q1", q, 8'hC8);
    applyStimulus(0, 8'h00, 1, 3'b010, 0, 0);
    checkOutput("asr q2", q, 8'hE4);
    checkOutput("asr done", done, 1);
    idleCycle();

    // Abort by load at the 3rd busy cycle
    sin_l = 0;
    applyStimulus(1, 8'hFF, 0, 3'b000, 0, 0);
    applyStimulus(0, 8'h00, 0, 3'b001, 1, 4'd6);
    idleCycle();
    checkOutput("abort q1", q, 8'h7F);
    idleCycle();
    checkOutput("abort q2", q, 8'h3F);
    applyStimulus(1, 8'h3C, 0, 3'b000, 0, 0);
    checkOutput("abort q", q, 8'h3C);
    checkOutput("abort busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("abort no done", done, 0);
      checkOutput("abort q hold", q, 8'h3C);
      idleCycle();
    end

    // Zero amount, then a start ignored during a burst
    applyStimulus(1, 8'h5A, 0, 3'b000, 0, 0);
    applyStimulus(0, 8'h00, 0, 3'b001, 1, 4'd0);
    checkOutput("zero q", q, 8'h5A);
    checkOutput("zero done", done, 1);
    checkOutput("zero busy", busy, 0);
    idleCycle();
    checkOutput("zero done drop", done, 0);
    checkOutput("zero q hold", q, 8'h5A);
    applyStimulus(0, 8'h00, 0, 3'b001, 1, 4'd4);
    busyCycles = 1;
    applyStimulus(0, 8'h00, 0, 3'b010, 1, 4'd1);
    checkOutput("ign q1", q, 8'h2D);
    for (int i = 0; i < 10 && busy; i++) begin
      busyCycles++;
      idleCycle();
    end
    checkOutput("ign busy len", busyCycles, 4);
    checkOutput("ign final q", q, 8'h05);
    checkOutput("ign done", done, 1);

    // Back-to-back: start accepted in the done cycle
    sin_r = 1;
    applyStimulus(0, 8'h00, 0, 3'b010, 1, 4'd1);
    checkOutput("b2b busy", busy, 1);
    idleCycle();
    checkOutput("b2b q", q, 8'h0B);
    checkOutput("b2b done", done, 1);
    sin_r = 0;

    // Amount larger than WIDTH
    applyStimulus(1, 8'h01, 0, 3'b000, 0, 0);
    applyStimulus(0, 8'h00, 0, 3'b100, 1, 4'd9);
    for (int i = 0; i < 9; i++) idleCycle();
    checkOutput("rol9 q", q, 8'h02);
    checkOutput("rol9 done", done, 1);
    sin_l = 1;
    applyStimulus(1, 8'h00, 0, 3'b000, 0, 0);
    applyStimulus(0, 8'h00, 0, 3'b001, 1, 4'd10);
    for (int i = 0; i < 10; i++) idleCycle();
    checkOutput("lsr10 q", q, 8'hFF);
    checkOutput("lsr10 done", done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
